// File: rtl/prbs_checker.sv
// PRBS-8 (x^8+x^6+x^5+x^4+1) word checker: seeds from the stream, locks, counts errors.
// Latency: one cycle from a valid din to locked/err_pulse/err_cnt update.
// Backpressure: none; words are consumed whenever vld is high, held state otherwise.
module prbs_checker #(
    parameter int LOCK_CNT = 8,
    parameter int LOSS_CNT = 4,
    parameter int ERR_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             vld,
    input  logic [7:0]       din,
    output logic             locked,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_cnt
);

    localparam int RUN_W  = $clog2(LOCK_CNT + 1);
    localparam int MISS_W = $clog2(LOSS_CNT + 1);
    // Comparing against count-1 lets the lock/loss decision use the current register value.
    localparam logic [RUN_W-1:0]  RUN_LAST  = RUN_W'(LOCK_CNT - 1);
    localparam logic [MISS_W-1:0] MISS_LAST = MISS_W'(LOSS_CNT - 1);

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

    // One step of the Fibonacci LFSR that produced the stream.
    function automatic logic [7:0] nxt(input logic [7:0] x);
        return {x[6:0], x[7] ^ x[5] ^ x[4] ^ x[3]};
    endfunction

    state_t             state, state_d;
    logic [7:0]         exp_q, exp_d;
    logic [RUN_W-1:0]   run_q, run_d;
    logic [MISS_W-1:0]  miss_q, miss_d;
    logic               pulse_d;
    logic               inc;
    logic [ERR_W-1:0]   cnt_d;

    // Next-state and datapath decisions for the search/verify/locked sequencer.
    always_comb begin
        state_d = state;
        exp_d   = exp_q;
        run_d   = run_q;
        miss_d  = miss_q;
        pulse_d = 1'b0;
        inc     = 1'b0;
        if (vld) begin
            case (state)
                SEARCH: begin
                    // All-zero is the LFSR's lock-up state and can never be a valid seed.
                    if (din != 8'h00) begin
                        exp_d   = nxt(din);
                        run_d   = '0;
                        state_d = VERIFY;
                    end
                end
                VERIFY: begin
                    if (din == exp_q) begin
                        exp_d = nxt(din);
                        run_d = run_q + RUN_W'(1);
                        if (run_q == RUN_LAST) begin
                            state_d = LOCKED;
                            miss_d  = '0;
                        end
                    end else if (din != 8'h00) begin
                        // Restart verification from the new word rather than falling back to search.
                        exp_d = nxt(din);
                        run_d = '0;
                    end else begin
                        state_d = SEARCH;
                    end
                end
                LOCKED: begin
                    // Flywheel: the local model free-runs so a corrupted word cannot derail it.
                    exp_d = nxt(exp_q);
                    if (din == exp_q) begin
                        miss_d = '0;
                    end else begin
                        pulse_d = 1'b1;
                        inc     = 1'b1;
                        miss_d  = miss_q + MISS_W'(1);
                        if (miss_q == MISS_LAST) begin
                            state_d = SEARCH;
                        end
                    end
                end
                default: begin
                    state_d = SEARCH;
                end
            endcase
        end
    end

    // Error counter: clear wins over a coincident increment; saturates at all-ones.
    always_comb begin
        cnt_d = err_cnt;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (err_cnt != {ERR_W{1'b1}})) begin
            cnt_d = err_cnt + ERR_W'(1);
        end
    end

    // State and output registers; locked tracks the registered state directly.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= SEARCH;
            exp_q     <= '0;
            run_q     <= '0;
            miss_q    <= '0;
            locked    <= 1'b0;
            err_pulse <= 1'b0;
            err_cnt   <= '0;
        end else begin
            state     <= state_d;
            exp_q     <= exp_d;
            run_q     <= run_d;
            miss_q    <= miss_d;
            locked    <= (state_d == LOCKED);
            err_pulse <= pulse_d;
            err_cnt   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_prbs_checker.sv
// Bench for prbs_checker: table vectors, directed corner sequences, randomized stream.
// Two instances: defaults, and ERR_W=2/LOSS_CNT=8 for saturation behaviour.
// Each cycle both instances are compared with a behavioural reference model.
module tb_prbs_checker;

    logic        clk = 1'b0;
    logic        rst, clr, vld;
    logic [7:0]  din;
    logic        locked1, pulse1;
    logic [15:0] cnt1;
    logic        locked2, pulse2;
    logic [1:0]  cnt2;

    int n_chk  = 0;
    int n_fail = 0;

    prbs_checker dut1 (
        .clk(clk), .rst(rst), .clr(clr), .vld(vld), .din(din),
        .locked(locked1), .err_pulse(pulse1), .err_cnt(cnt1)
    );

    prbs_checker #(.LOCK_CNT(8), .LOSS_CNT(8), .ERR_W(2)) dut2 (
        .clk(clk), .rst(rst), .clr(clr), .vld(vld), .din(din),
        .locked(locked2), .err_pulse(pulse2), .err_cnt(cnt2)
    );

    always #5 clk = ~clk;

    // Reference model state: mode 0 = searching, 1 = verifying, 2 = locked.
    typedef struct packed {
        int      mode;
        int      run;
        int      miss;
        int      cnt;
        bit [7:0] expv;
        bit      locked;
        bit      pulse;
    } mdl_t;

    mdl_t m1, m2;
    bit [7:0] g;

    function automatic bit [7:0] nx(bit [7:0] x);
        return {x[6:0], x[7] ^ x[5] ^ x[4] ^ x[3]};
    endfunction

    function automatic mdl_t mstep(mdl_t m, bit r, bit c, bit v, bit [7:0] d,
                                   int lk, int ls, int mx);
        mdl_t n;
        n = m;
        n.pulse = 1'b0;
        if (r) begin
            n = '0;
            return n;
        end
        if (c) n.cnt = 0;
        if (v) begin
            if (m.mode == 0) begin
                if (d != 0) begin
                    n.expv = nx(d); n.run = 0; n.mode = 1;
                end
            end else if (m.mode == 1) begin
                if (d == m.expv) begin
                    n.expv = nx(d); n.run = m.run + 1;
                    if (n.run == lk) begin n.mode = 2; n.miss = 0; end
                end else if (d != 0) begin
                    n.expv = nx(d); n.run = 0;
                end else begin
                    n.mode = 0;
                end
            end else begin
                n.expv = nx(m.expv);
                if (d == m.expv) begin
                    n.miss = 0;
                end else begin
                    n.pulse = 1'b1;
                    if (!c && m.cnt < mx) n.cnt = m.cnt + 1;
                    n.miss = m.miss + 1;
                    if (n.miss == ls) n.mode = 0;
                end
            end
        end
        n.locked = (n.mode == 2);
        return n;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, req, $time);
        end
    endtask

    // Apply one cycle of inputs, advance the models at the edge, compare just after it.
    task automatic step(bit r, bit c, bit v, bit [7:0] d);
        rst = r; clr = c; vld = v; din = d;
        @(posedge clk);
        m1 = mstep(m1, r, c, v, d, 8, 4, 65535);
        m2 = mstep(m2, r, c, v, d, 8, 8, 3);
        #1;
        chk("mdl1_locked", locked1, m1.locked);
        chk("mdl1_pulse",  pulse1,  m1.pulse);
        chk("mdl1_cnt",    cnt1,    m1.cnt);
        chk("mdl2_locked", locked2, m2.locked);
        chk("mdl2_pulse",  pulse2,  m2.pulse);
        chk("mdl2_cnt",    cnt2,    m2.cnt);
    endtask

    task automatic good();
        step(0, 0, 1, g);
        g = nx(g);
    endtask

    task automatic bad();
        step(0, 0, 1, g ^ 8'h01);
        g = nx(g);
    endtask

    typedef struct {
        bit       r, c, v;
        bit [7:0] d;
        bit       e_locked, e_pulse;
        int       e_cnt;
    } vec_t;

    vec_t tbl[18];

    initial begin
        m1 = '0; m2 = '0;
        rst = 1'b1; clr = 1'b0; vld = 1'b0; din = 8'h00;

        // Vector table: reset, 12 good words from seed 0x01, one corrupted word, recovery.
        tbl[0] = '{r:1, c:0, v:0, d:8'h00, e_locked:0, e_pulse:0, e_cnt:0};
        g = 8'h01;
        for (int i = 1; i <= 12; i++) begin
            tbl[i] = '{r:0, c:0, v:1, d:g, e_locked:(i >= 9), e_pulse:0, e_cnt:0};
            g = nx(g);
        end
        tbl[13] = '{r:0, c:0, v:1, d:(g ^ 8'h01), e_locked:1, e_pulse:1, e_cnt:1};
        g = nx(g);
        for (int i = 14; i <= 16; i++) begin
            tbl[i] = '{r:0, c:0, v:1, d:g, e_locked:1, e_pulse:0, e_cnt:1};
            g = nx(g);
        end
        tbl[17] = '{r:0, c:0, v:0, d:8'hFF, e_locked:1, e_pulse:0, e_cnt:1};

        for (int i = 0; i < 18; i++) begin
            step(tbl[i].r, tbl[i].c, tbl[i].v, tbl[i].d);
            chk("tbl_locked", locked1, tbl[i].e_locked);
            chk("tbl_pulse",  pulse1,  tbl[i].e_pulse);
            chk("tbl_cnt",    cnt1,    tbl[i].e_cnt);
        end

        // Four consecutive corrupted words drop lock after the fourth; nine good words relock.
        for (int k = 0; k < 4; k++) begin
            bad();
            chk("loss_locked", locked1, (k < 3) ? 1 : 0);
            chk("loss_pulse",  pulse1, 1);
        end
        chk("loss_cnt", cnt1, 5);
        for (int k = 0; k < 9; k++) begin
            good();
            chk("relock_locked", locked1, (k == 8) ? 1 : 0);
        end
        chk("relock_cnt", cnt1, 5);

        // All-zero input never seeds the checker.
        step(1, 0, 0, 8'h00);
        for (int k = 0; k < 20; k++) step(0, 0, 1, 8'h00);
        chk("zero_locked", locked1, 0);
        chk("zero_cnt",    cnt1,    0);

        // Isolated errors: the 2-bit counter saturates at 3; clear beats a coincident error.
        step(1, 0, 0, 8'h00);
        g = 8'h5A;
        for (int k = 0; k < 9; k++) good();
        chk("sat_lock1", locked1, 1);
        chk("sat_lock2", locked2, 1);
        for (int k = 0; k < 5; k++) begin
            bad();
            good();
        end
        chk("sat_cnt2", cnt2, 3);
        chk("sat_cnt1", cnt1, 5);
        step(0, 1, 1, g ^ 8'h01);
        g = nx(g);
        chk("clr_cnt2",   cnt2,   0);
        chk("clr_cnt1",   cnt1,   0);
        chk("clr_pulse2", pulse2, 1);

        // Reset while locked (with a pending error) clears every output next cycle.
        bad();
        step(1, 1, 1, g ^ 8'h01);
        chk("rst_locked", locked1, 0);
        chk("rst_pulse",  pulse1,  0);
        chk("rst_cnt",    cnt1,    0);

        // Gaps in vld during acquisition: lock follows exactly the ninth valid word.
        g = 8'hC3;
        for (int k = 0; k < 9; k++) begin
            step(0, 0, 0, 8'($urandom));
            good();
            chk("gap_locked", locked1, (k == 8) ? 1 : 0);
        end

        // Randomized stream: mostly good, with corruption, zeros, reseeds, clears, resets.
        for (int k = 0; k < 3000; k++) begin
            bit r, c, v;
            bit [7:0] d;
            int sel;
            r = ($urandom_range(0, 999) == 0);
            c = ($urandom_range(0, 63) == 0);
            v = ($urandom_range(0, 3) != 0);
            sel = $urandom_range(0, 99);
            if (sel == 0) g = 8'($urandom_range(1, 255));
            if (sel < 90)      d = g;
            else if (sel < 97) d = g ^ 8'($urandom_range(1, 255));
            else               d = 8'h00;
            step(r, c, v, d);
            if (v) g = nx(g);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
